// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Load/store request and response channels between the memory stage
//   (master) and the data-memory responder (slave).
//   Request : req_valid/req_ready handshake carrying we, byte address,
//             store data and store byte enables.
//   Response: rsp_valid/rsp_ready handshake carrying read data and an
//             error flag (out-of-range or misaligned request).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the core's load/store path. Accepts one request at a time,
//   holds a word-organised RAM of 2**ADDR_W 32-bit words with byte enables,
//   and answers loads after RD_LATENCY cycles, stores and faults after one.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset (FSM and response registers only;
//          RAM contents survive reset)
//   bus  : dmem_responder_if.slave - request and response channels
//
// Parameters
//   ADDR_W     : word-address width
//   RD_LATENCY : acceptance-to-response cycles for loads, 1..15
//
// Build option
//   DMEM_ALIGN_CHECK_EN : when defined, byte addresses with nonzero [1:0]
//                         fault; otherwise the low two bits are ignored.
module dmem_responder #(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       mem [0:DEPTH-1];

  logic [ADDR_W-1:0] idx_req;
  logic [ADDR_W-1:0] idx_p0;
  logic [ADDR_W-1:0] rd_idx;
  logic              accept;
  logic              range_err;
  logic              align_err;
  logic              req_err;
  logic              wr_en;
  logic              enter_resp;
  logic              rd_en;
  logic              rsp_err_d;

  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  assign bus.req_ready = (state_q == IDLE);
  assign accept        = bus.req_valid && (state_q == IDLE);
  assign idx_req       = bus.req_addr[ADDR_W+1:2];
  assign range_err     = |bus.req_addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = |bus.req_addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign align_err       = 1'b0;
`endif

  assign req_err = range_err | align_err;

  // Loads entering RESP straight from IDLE (RD_LATENCY == 1) read the live
  // request address; loads coming out of WAIT use the captured index.
  assign rd_idx    = (state_q == IDLE) ? idx_req : idx_p0;
  assign rsp_err_d = (state_q == IDLE) ? req_err : 1'b0;
  assign rd_en     = enter_resp &&
                     ((state_q == WAIT) || (!bus.req_we && !req_err));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en = bus.req_we && !req_err;
          if (bus.req_we || req_err || (RD_LATENCY == 1)) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control stage: FSM and latency counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture stage: word index for delayed loads
  always_ff @(posedge clk) begin
    if (accept) idx_p0 <= idx_req;
  end

  // RAM write port: reset blocks any write in the reset cycle
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_be[b]) mem[idx_req][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  // Response stage: registered on entry to RESP, held until handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (enter_resp) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rd_en ? mem[rd_idx] : 32'd0;
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. The driver pushes an expected
//   response (from a byte-level memory model) when each request is
//   accepted; an independent monitor pops and compares on every response
//   handshake, and also checks hold-while-stalled and latency.
module tb_dmem_responder;
  localparam int ADDR_W = 10;
  localparam int RD_L   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    logic        err;
    bit          neq;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [int];
  logic [3:0]  kn [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  bit          force_rdy = 1'b1;
  logic        rdy_val   = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Consumer-side ready: random unless a directed test pins it.
  always begin
    @(posedge clk);
    #1;
    bus.rsp_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  // Reference model: what the response to a request must be, from the
  // addressing rules and a byte-tracked shadow of the RAM.
  function automatic exp_t model(input bit we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    int   w;
    bit   err;
    w   = int'(a[ADDR_W+1:2]);
    err = (a >> (ADDR_W + 2)) != 0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) err = 1'b1;
`endif
    e.err = err; e.neq = 1'b0; e.exp = 32'd0; e.mask = 32'hFFFF_FFFF; e.lat = 1; e.acc = 0;
    if (!err && we) begin
      if (!mm.exists(w)) begin mm[w] = 32'd0; kn[w] = 4'd0; end
      for (int b = 0; b < 4; b++)
        if (be[b]) begin
          mm[w][8*b +: 8] = wd[8*b +: 8];
          kn[w][b] = 1'b1;
        end
    end else if (!err) begin
      e.lat  = RD_L;
      e.mask = 32'd0;
      if (mm.exists(w)) begin
        e.exp = mm[w];
        for (int b = 0; b < 4; b++) if (kn[w][b]) e.mask[8*b +: 8] = 8'hFF;
      end
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance with
  // req_valid still high so a following call issues without a gap.
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit push, input bit neq);
    int   n;
    exp_t e;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_be = be;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 200) begin
        chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        break;
      end
    end
    if (push) begin
      e     = model(we, a, wd, be);
      e.acc = cyc;
      e.neq = neq;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle_req();
    force_rdy = 1'b1; rdy_val = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (q.size() == 0 && !bus.rsp_valid) break;
      n++;
      if (n > 500) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every response handshake against the scoreboard.
  bit          pv = 1'b0, pr = 1'b0, phs = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;
  int          rise = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pv  = 1'b0; pr = 1'b0; phs = 1'b0;
    end else begin
      if (phs) begin
        chk("ready_after_hs", 32'(bus.req_ready), 32'd1);
        chk("valid_cleared", 32'(bus.rsp_valid), 32'd0);
      end
      if (pv && !pr) begin
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_rdata", bus.rsp_rdata, hold_rdata);
        chk("hold_err", 32'(bus.rsp_err), 32'(hold_err));
      end
      if (bus.rsp_valid) begin
        chk("busy_not_ready", 32'(bus.req_ready), 32'd0);
        if (!pv) rise = cyc;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          if (e.neq)
            chk("rst_store_dropped", 32'(bus.rsp_rdata != 32'hDEAD_BEEF), 32'd1);
          else
            chk("rsp_rdata", bus.rsp_rdata & e.mask, e.exp & e.mask);
          chk("latency", 32'(rise - e.acc), 32'(e.lat));
        end
      end
      phs        = bus.rsp_valid && bus.rsp_ready;
      pv         = bus.rsp_valid;
      pr         = bus.rsp_ready;
      hold_rdata = bus.rsp_rdata;
      hold_err   = bus.rsp_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rsp_ready = 1'b1;
    // Reset with a store held on the request channel: it must be dropped.
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hDEAD_BEEF; bus.req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1);

    // Store then load, then a partial-byte store.
    issue(1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0);
    // be = 0 store is an acknowledged no-op.
    issue(1'b1, 32'h44, 32'h0102_0304, 4'hF, 1'b1, 1'b0);
    issue(1'b1, 32'h44, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0);
    // Out of range: no aliasing onto word 0.
    issue(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0);
    issue(1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h1000, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b1, 1'b0);
    // Misaligned load of word 0x40.
    issue(1'b0, 32'h42, 32'h0, 4'h0, 1'b1, 1'b0);
    drain();

    // Backpressure: response held 5 cycles, then back-to-back request.
    force_rdy = 1'b1; rdy_val = 1'b0; bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0);
    idle_req();
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rdy_val = 1'b1; bus.rsp_ready = 1'b1;
    issue(1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0);
    drain();

    // Reset during WAIT: the load is abandoned with no response.
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);
    idle_req();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
    chk("no_rsp_after_abort", 32'(bus.rsp_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_abort", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer readiness.
    force_rdy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      bit          we;
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(ADDR_W + 2, 31));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(we, a, $urandom, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idle_req();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the memory stage of the pipelined core: the slave end of the load/store path.
- Accepts one load/store request at a time over a valid/ready handshake and holds word-organised RAM with byte enables.
- Returns read data or a store acknowledgement over a valid/ready response channel after a fixed, parameterised latency.
- Gives the memory stage a stallable, latency-tolerant memory interface in place of a zero-wait array.

Parameters:
- ADDR_W, 10, word-address width; RAM holds 2**ADDR_W 32-bit words.
- RD_LATENCY, 2, cycles from request acceptance to read response; legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i writes byte i (bits 8i+7:8i); ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request faulted (out of range or misaligned).

Behaviour:
- Reset (rst low at a rising edge):
  - state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - RAM contents are not cleared.
  - Reset has priority over everything: a request handshaking in the reset cycle is dropped and no RAM write occurs.
  - Reset mid-WAIT or mid-RESP aborts the transaction; no response is produced.
- FSM states IDLE, WAIT, RESP. req_ready = (state == IDLE), decoded from state only; never depends on req_valid.
- Acceptance at cycle T (req_valid && req_ready in IDLE):
  - Capture we, addr, wdata, be.
  - Fault check: out of range if req_addr[31:ADDR_W+2] != 0; misaligned per the optional feature.
  - Store, no fault: RAM word req_addr[ADDR_W+1:2] is updated at the end of cycle T, enabled bytes only. Next state RESP; rsp_valid = 1 from T+1 with rsp_rdata = 0, rsp_err = 0.
  - Any fault: no RAM write. Next state RESP; rsp_valid = 1 from T+1 with rsp_err = 1, rsp_rdata = 0.
  - Load, no fault, RD_LATENCY = 1: next state RESP; rsp_valid from T+1.
  - Load, no fault, RD_LATENCY > 1: next state WAIT with counter loaded to RD_LATENCY-2. Counter decrements each cycle; at 0, go to RESP. rsp_valid rises in cycle T+RD_LATENCY.
  - Load data: the RAM word is read synchronously and registered into rsp_rdata on entry to RESP. It reflects all stores that completed before T.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready = 1.
  - On the rsp_valid && rsp_ready cycle, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err next cycle.
  - The earliest next acceptance is the cycle after the response handshake. At most one transaction is outstanding.
- Throughput: back-to-back loads with rsp_ready held at 1 complete one every RD_LATENCY+1 cycles; stores every 2 cycles.
- req_wdata and req_be are ignored for loads. req_be = 0 on a store is a legal no-op write that is still acknowledged.
- Address wrap: none. Any address beyond the RAM size is an error and is never aliased.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: req_addr[1:0] != 2'b00 flags misaligned. The request gets rsp_err = 1, has no RAM effect, and follows the same timing as other faults.
- Undefined: req_addr[1:0] is ignored. The word at req_addr[ADDR_W+1:2] is accessed and no misalignment error ever occurs.

Test Plan:
- Reset: drive rst low 2 cycles with req_valid = 1, we = 1, addr 0x10, wdata 0xDEADBEEF. Then load 0x10 -> rsp_rdata is not 0xDEADBEEF (stale/X-free preloaded value); during reset rsp_valid = 0 and req_ready = 0 or IDLE-high with no write performed.
- Store then load, RD_LATENCY = 2: store 0x12345678 be = 4'hF to 0x40; ack at T+1. Load 0x40 accepted at T' -> rsp_valid exactly at T'+2 with rsp_rdata 0x12345678, rsp_err 0.
- Byte enables: word 0x40 = 0x12345678; store 0xAABBCCDD with be = 4'b0101 -> load returns 0x12BB56DD.
- Out of range, ADDR_W = 10: load 0x00001000 -> rsp_err 1, rsp_rdata 0. Store to 0x00001000 -> rsp_err 1, and word 0 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles after a load response -> rsp_valid, rsp_rdata and rsp_err remain stable and req_ready stays 0. Raise rsp_ready -> IDLE next cycle and a new request is accepted the following cycle.
- Alignment: load 0x42 -> with DMEM_ALIGN_CHECK_EN, rsp_err 1; without it, rsp_err 0 and data of word 0x40 is returned.
- Reset mid-WAIT: assert rst during WAIT -> no response ever appears and req_ready = 1 the cycle after rst is released.
